// File: rtl/loc_sequencer_if.sv
// Control/status bundle between HPS registers, pipeline done
// pulses and the per-frame localizer sequencer.
interface loc_sequencer_if #(
  parameter int FRAME_W = 16
) ();
  logic               start;
  logic               cont_en;
  logic               clr_err;
  logic               fifo_full;
  logic               fftdone;
  logic               detectdone;
  logic               wbdone;
  logic [7:0]         doa_x_in;
  logic [7:0]         doa_y_in;
  logic               cap_go;
  logic               busy;
  logic [2:0]         state_o;
  logic               err_timeout;
  logic [2:0]         err_stage;
  logic [7:0]         doa_x;
  logic [7:0]         doa_y;
  logic               result_valid;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output start, cont_en, clr_err,
    output fifo_full, fftdone,
    output detectdone, wbdone,
    output doa_x_in, doa_y_in,
    input  cap_go, busy, state_o,
    input  err_timeout, err_stage,
    input  doa_x, doa_y,
    input  result_valid, frame_cnt
  );

  modport slave (
    input  start, cont_en, clr_err,
    input  fifo_full, fftdone,
    input  detectdone, wbdone,
    input  doa_x_in, doa_y_in,
    output cap_go, busy, state_o,
    output err_timeout, err_stage,
    output doa_x, doa_y,
    output result_valid, frame_cnt
  );
endinterface

// File: rtl/loc_sequencer.sv
// Frame sequencer: capture -> FFT -> detect -> weight, with
// stretched cap_go, per-stage timeout and latched DOA results.
module loc_sequencer #(
  parameter int STRETCH     = 16,
  parameter int TIMEOUT_CYC = 4000000,
  parameter int HOLDOFF_CYC = 1000,
  parameter int FRAME_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  loc_sequencer_if.slave bus
);
  localparam int M1 =
    (TIMEOUT_CYC > HOLDOFF_CYC) ? TIMEOUT_CYC : HOLDOFF_CYC;
  localparam int MX = (M1 > STRETCH) ? M1 : STRETCH;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] L_STR = CW'(STRETCH);
  localparam logic [CW-1:0] L_TMO = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] L_HLD = CW'(HOLDOFF_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_FFT     = 3'd2,
    S_DETECT  = 3'd3,
    S_WEIGHT  = 3'd4,
    S_DONE    = 3'd5,
    S_HOLDOFF = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nx;
  logic               w_tmo;
  logic               w_counted;
  logic               r_cap_go;
  logic               r_busy;
  logic               r_err;
  logic [2:0]         r_err_stage;
  logic [7:0]         r_doa_x;
  logic [7:0]         r_doa_y;
  logic               r_rv;
  logic [FRAME_W-1:0] r_frame;

  assign w_tmo = (r_cnt == L_TMO);
  assign w_counted = r_state inside
    {S_CAPTURE, S_FFT, S_DETECT, S_WEIGHT, S_HOLDOFF};

  // Exit conditions are tested before expiry so a late pulse wins
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start || bus.cont_en) w_state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (r_cnt >= L_STR && bus.fifo_full)
          w_state_nx = S_FFT;
        else if (w_tmo)
          w_state_nx = S_ERR;
      end
      S_FFT: begin
        if (bus.fftdone)  w_state_nx = S_DETECT;
        else if (w_tmo)   w_state_nx = S_ERR;
      end
      S_DETECT: begin
        if (bus.detectdone) w_state_nx = S_WEIGHT;
        else if (w_tmo)     w_state_nx = S_ERR;
      end
      S_WEIGHT: begin
        if (bus.wbdone) w_state_nx = S_DONE;
        else if (w_tmo) w_state_nx = S_ERR;
      end
      S_DONE: begin
        w_state_nx = bus.cont_en ? S_HOLDOFF : S_IDLE;
      end
      S_HOLDOFF: begin
        if (!bus.cont_en)        w_state_nx = S_IDLE;
        else if (r_cnt == L_HLD) w_state_nx = S_CAPTURE;
      end
      S_ERR: begin
        if (bus.clr_err) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nx = '0;
    if (w_counted && w_state_nx == r_state)
      w_cnt_nx = r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cap_go    <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= 3'd0;
      r_doa_x     <= 8'd0;
      r_doa_y     <= 8'd0;
      r_rv        <= 1'b0;
      r_frame     <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_cap_go <= (w_state_nx == S_CAPTURE) && (w_cnt_nx < L_STR);
      r_busy   <= (w_state_nx != S_IDLE) && (w_state_nx != S_ERR);
      r_rv     <= (w_state_nx == S_DONE);
      if (w_state_nx == S_DONE) begin
        r_doa_x <= bus.doa_x_in;
        r_doa_y <= bus.doa_y_in;
        r_frame <= r_frame + FRAME_W'(1);
      end
      if (r_state != S_ERR && w_state_nx == S_ERR) begin
        r_err       <= 1'b1;
        r_err_stage <= r_state;
      end else if (r_state == S_ERR && w_state_nx == S_IDLE) begin
        r_err       <= 1'b0;
        r_err_stage <= 3'd0;
      end
    end
  end

  assign bus.cap_go       = r_cap_go;
  assign bus.busy         = r_busy;
  assign bus.state_o      = r_state;
  assign bus.err_timeout  = r_err;
  assign bus.err_stage    = r_err_stage;
  assign bus.doa_x        = r_doa_x;
  assign bus.doa_y        = r_doa_y;
  assign bus.result_valid = r_rv;
  assign bus.frame_cnt    = r_frame;
endmodule

// File: tb/tb_loc_sequencer.sv
// Bench for loc_sequencer: frame table, result scoreboard and
// hand-built timeout / reset / stray-pulse sequences.
module tb_loc_sequencer;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  loc_sequencer_if #(.FRAME_W(FW)) bus ();

  loc_sequencer #(
    .STRETCH    (16),
    .TIMEOUT_CYC(100),
    .HOLDOFF_CYC(10),
    .FRAME_W    (FW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int         t_full;
    int         t_sfft;
    int         t_swb;
    int         t_fft;
    int         t_det;
    int         t_wb;
    int         t_drop;
    logic [7:0] dx;
    logic [7:0] dy;
    int         exp_fft_in;
    int         exp_dx;
    int         exp_dy;
    int         exp_next;
  } frame_t;

  typedef struct {
    int dx;
    int dy;
    int fc;
  } res_t;

  frame_t tbl[6];
  res_t   sb[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     exp_fc = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.start      = 1'b0;
    bus.cont_en    = 1'b0;
    bus.clr_err    = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.fftdone    = 1'b0;
    bus.detectdone = 1'b0;
    bus.wbdone     = 1'b0;
    bus.doa_x_in   = 8'd0;
    bus.doa_y_in   = 8'd0;
  endtask

  task automatic chk_zero(input string nm);
    @(negedge clk);
    chk(nm, {bus.cap_go, bus.busy, bus.state_o,
             bus.err_timeout, bus.err_stage, bus.doa_x,
             bus.doa_y, bus.result_valid, bus.frame_cnt}, 0);
    nxt();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rv_unexpected", 1, 0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("sb_doa_x", $signed(bus.doa_x), e.dx);
        chk("sb_doa_y", $signed(bus.doa_y), e.dy);
        chk("sb_frame_cnt", bus.frame_cnt, e.fc);
      end
    end
  end

  // Entered in the first CAPTURE cycle; r counts cycles from there
  task automatic run_frame(input frame_t f, input string tag);
    int   capn;
    int   capl;
    int   fftin;
    int   rvn;
    int   rvc;
    res_t e;
    capn = 0; capl = -1; fftin = -1; rvn = 0; rvc = -1;
    for (int r = 0; r <= f.t_wb + 2; r++) begin
      bus.fifo_full  = (r >= f.t_full) && (r <= f.t_wb);
      bus.fftdone    = (r == f.t_fft) || (r == f.t_sfft);
      bus.detectdone = (r == f.t_det);
      bus.wbdone     = (r == f.t_wb) || (r == f.t_swb);
      bus.doa_x_in   = f.dx;
      bus.doa_y_in   = f.dy;
      if (r == f.t_drop) bus.cont_en = 1'b0;
      if (r == f.t_wb) begin
        exp_fc = (exp_fc + 1) % (1 << FW);
        e.dx = f.exp_dx;
        e.dy = f.exp_dy;
        e.fc = exp_fc;
        sb.push_back(e);
      end
      @(negedge clk);
      if (r == 0)
        chk($sformatf("%s_entry", tag), bus.state_o, 1);
      if (bus.cap_go) begin
        capn++;
        capl = r;
      end
      if (fftin < 0 && bus.state_o == 3'd2) fftin = r;
      if (bus.result_valid) begin
        rvn++;
        rvc = r;
      end
      if (r == f.t_wb + 2)
        chk($sformatf("%s_next", tag), bus.state_o, f.exp_next);
      nxt();
    end
    chk($sformatf("%s_cap_cnt", tag), capn, 16);
    chk($sformatf("%s_cap_last", tag), capl, 15);
    chk($sformatf("%s_fft_in", tag), fftin, f.exp_fft_in);
    chk($sformatf("%s_rv_cnt", tag), rvn, 1);
    chk($sformatf("%s_rv_cyc", tag), rvc, f.t_wb + 1);
    chk($sformatf("%s_err", tag), bus.err_timeout, 0);
    bus.fifo_full  = 1'b0;
    bus.fftdone    = 1'b0;
    bus.detectdone = 1'b0;
    bus.wbdone     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    nxt();
    nxt();
    rst_n = 1'b1;
    exp_fc = 0;
    sb.delete();
  endtask

  initial begin
    int fftin;
    int errin;
    int hold;

    tbl[0] = '{39, -1, -1,  59,  79,  99, -1,
               8'hE2, 8'h1E, 40,  -30,   30, 0};
    tbl[1] = '{20, -1, -1,  30,  35,  40, -1,
               8'h05, 8'hFB, 21,    5,   -5, 6};
    tbl[2] = '{16, -1, -1,  17,  18,  19, -1,
               8'h7F, 8'h80, 17,  127, -128, 6};
    tbl[3] = '{25, -1, -1,  40,  45,  50, 30,
               8'h00, 8'h01, 26,    0,    1, 0};
    tbl[4] = '{ 0,  5, 10,  30,  40,  50, -1,
               8'h9C, 8'h64, 17, -100,  100, 0};
    tbl[5] = '{16, -1, -1, 116, 150, 160, -1,
               8'h81, 8'h7E, 17, -127,  126, 0};

    do_reset();
    chk_zero("reset_outputs");

    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    run_frame(tbl[0], "single");

    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    bus.fifo_full = 1'b1;
    fftin = -1;
    errin = -1;
    for (int r = 0; r < 200 && errin < 0; r++) begin
      @(negedge clk);
      if (fftin < 0 && bus.state_o == 3'd2) fftin = r;
      if (bus.state_o == 3'd7) errin = r;
      nxt();
    end
    bus.fifo_full = 1'b0;
    chk("tmo_delay", errin - fftin, 100);
    chk("tmo_flag", bus.err_timeout, 1);
    chk("tmo_stage", bus.err_stage, 2);
    chk("tmo_busy", bus.busy, 0);
    chk("tmo_cap_go", bus.cap_go, 0);

    bus.start = 1'b1;
    bus.cont_en = 1'b1;
    nxt();
    nxt();
    nxt();
    @(negedge clk);
    chk("err_ignores_start", bus.state_o, 7);
    chk("err_hold_x", $signed(bus.doa_x), -30);
    chk("err_hold_y", $signed(bus.doa_y), 30);
    chk("err_hold_fc", bus.frame_cnt, 1);
    nxt();
    bus.start = 1'b0;
    bus.cont_en = 1'b0;
    bus.clr_err = 1'b1;
    nxt();
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("clr_state", bus.state_o, 0);
    chk("clr_flag", bus.err_timeout, 0);
    chk("clr_stage", bus.err_stage, 0);
    nxt();
    bus.clr_err = 1'b1;
    nxt();
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("clr_idle_state", bus.state_o, 0);
    chk("clr_idle_busy", bus.busy, 0);
    nxt();

    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    bus.fifo_full = 1'b1;
    for (int r = 0; r < 20; r++) begin
      bus.fftdone = (r == 17);
      bus.detectdone = (r == 18);
      @(negedge clk);
      if (r == 19) chk("rst_in_weight", bus.state_o, 4);
      nxt();
    end
    clr_in();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    exp_fc = 0;
    chk_zero("rst_mid_weight");

    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    run_frame(tbl[0], "post_rst");

    do_reset();
    bus.cont_en = 1'b1;
    nxt();
    for (int i = 1; i <= 3; i++) begin
      run_frame(tbl[i], $sformatf("cont%0d", i));
      if (i < 3) begin
        hold = 1;
        for (int h = 0; h < 9; h++) begin
          @(negedge clk);
          if (bus.state_o == 3'd6 && !bus.cap_go) hold++;
          nxt();
        end
        chk($sformatf("holdoff%0d", i), hold, 10);
      end
    end

    for (int i = 4; i <= 5; i++) begin
      bus.start = 1'b1;
      nxt();
      bus.start = 1'b0;
      run_frame(tbl[i], $sformatf("row%0d", i));
    end

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
